// File: rtl/rca_nibble_sequencer.sv
// Purpose : WIDTH-bit adder built by time-sharing one 4-bit ripple-carry adder, LSB nibble first.
// Latency : out_valid rises exactly NIBBLES cycles after the accepting edge; one op per NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE (no queueing); result/cout_out held in DONE until out_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        operand handshake (op_a, op_b, op_cin[, op_sub])
//   out_valid / out_ready      result handshake (result, cout_out)
//   busy                       high while an operation is in ADD or DONE
// Optional feature macro: SEQ_SUB_EN adds port op_sub (A - B, cout_out=1 means no borrow).

module rca_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
`ifdef SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout_out,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
        $error("rca_nibble_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;

    // Shared 4-bit ripple-carry adder slice
    logic [3:0]        rca_a, rca_b, rca_sum;
    logic              rca_cin, rca_cout;

    // Nibble select: bit offset is idx*4
    assign rca_a   = a_q[{idx_q, 2'b00} +: 4];
    assign rca_b   = b_q[{idx_q, 2'b00} +: 4];
    assign rca_cin = carry_q;

    always_comb begin : rca4
        logic c;
        c       = rca_cin;
        rca_sum = '0;
        for (int i = 0; i < 4; i++) begin
            rca_sum[i] = rca_a[i] ^ rca_b[i] ^ c;
            c          = (rca_a[i] & rca_b[i]) | (c & (rca_a[i] ^ rca_b[i]));
        end
        rca_cout = c;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = op_cin;
`ifdef SEQ_SUB_EN
                    // Two's complement subtract: A + ~B + 1; op_cin is not used
                    if (op_sub) begin
                        b_d     = ~op_b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                result_d[{idx_q, 2'b00} +: 4] = rca_sum;
                carry_d = rca_cout;
                if (idx_q == LAST_IDX) begin
                    // Clear rather than increment so idx never leaves 0..NIBBLES-1
                    idx_d   = '0;
                    cout_d  = rca_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign cout_out  = cout_q;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
module tb_rca_nibble_sequencer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
`ifdef SEQ_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout_out;
    logic             busy;

    int vectors;
    int miscompares;

    rca_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
`ifdef SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout_out  (cout_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input int hold, input string tag);
        logic [16:0] full;
        logic [15:0] exp_res;
        logic        exp_cout;
        logic [31:0] r;
        int          cyc;
        if (sub) begin
            exp_res  = a - b;
            exp_cout = (a >= b);
        end else begin
            full     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            exp_res  = full[15:0];
            exp_cout = full[16];
        end

        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);

        op_a     = a;
        op_b     = b;
        op_cin   = cin;
`ifdef SEQ_SUB_EN
        op_sub   = sub;
`endif
        in_valid = 1'b1;
        tick();

        // Scramble inputs after the accept; they must be ignored
        r        = $urandom;
        op_a     = r[15:0];
        op_b     = r[31:16];
        op_cin   = r[0];
        in_valid = r[1];
`ifdef SEQ_SUB_EN
        op_sub   = r[2];
`endif
        chk({tag, ".busy_add"}, {31'd0, busy}, 32'd1);
        chk({tag, ".in_ready_add"}, {31'd0, in_ready}, 32'd0);

        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 32'd4);
        chk({tag, ".result"}, {16'd0, result}, {16'd0, exp_res});
        chk({tag, ".cout"}, {31'd0, cout_out}, {31'd0, exp_cout});

        for (int h = 0; h < hold; h++) begin
            r        = $urandom;
            in_valid = r[0];
            op_a     = r[31:16];
            out_ready = 1'b0;
            tick();
            chk({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ".hold_result"}, {16'd0, result}, {16'd0, exp_res});
            chk({tag, ".hold_cout"}, {31'd0, cout_out}, {31'd0, exp_cout});
            chk({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".release_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".release_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".release_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".result"}, {16'd0, result}, 32'd0);
        chk({tag, ".cout"}, {31'd0, cout_out}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] s;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        op_a        = '0;
        op_b        = '0;
        op_cin      = 1'b0;
`ifdef SEQ_SUB_EN
        op_sub      = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Directed arithmetic
        run_op(16'h0005, 16'h0003, 1'b0, 1'b0, 0, "add_small");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "ripple_ffff");
        run_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 0, "ripple_aaaa");

        // Backpressure in DONE, then a fresh accept
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 5, "backpressure");
        run_op(16'h0100, 16'h00FF, 1'b1, 1'b0, 0, "after_bp");

        // Abort mid-ADD at idx=2
        op_a     = 16'h9999;
        op_b     = 16'h8888;
        op_cin   = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        tick();
        rst_n = 1'b1;
        tick();
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, "post_abort");

`ifdef SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_borrow");
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, "sub_noborrow");
`endif

        // Randomized operations with random backpressure
        for (int n = 0; n < 24; n++) begin
            r = $urandom;
            s = $urandom;
`ifdef SEQ_SUB_EN
            run_op(r[15:0], r[31:16], s[0], s[1], int'(s[5:4]), "rand");
`else
            run_op(r[15:0], r[31:16], s[0], 1'b0, int'(s[5:4]), "rand");
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
